board_scanner: RTL and testbench
================================

Name: board_scanner

Overview:
- Upstream feeder for Transmitter. Holds the 64-square board image and, on command, walks squares 0..63 in order.
- For every square occupied by a piece of the engine's colour it presents {piece_reg, pos_reg, engine_color} with a valid/ready handshake.
- Transmitter consumes these to generate ray and knight outputs. Scan completion is flagged so the move-generation controller can sequence the next ply.

Parameters:
- SQ_W, 6, square index width (64 squares; [5:3] rank, [2:0] file)
- PIECE_W, 6, piece code width: bit 5 = colour (1 = WHITE, 0 = BLACK), [4:0] = type
- CNT_W, 7, width of emitted-piece counter (0..64)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  board write strobe (IDLE only)
- wr_addr  in  SQ_W  square to write
- wr_data  in  PIECE_W  piece code; type 00000 = EMPTY
- start  in  1  one-cycle scan request
- color_in  in  1  side to move, sampled on accepted start
- out_ready  in  1  Transmitter stage accepts current piece
- out_valid  out  1  piece_reg/pos_reg/engine_color valid
- piece_reg  out  PIECE_W  piece code of current square
- pos_reg  out  SQ_W  current square index
- engine_color  out  1  latched side to move
- busy  out  1  high in SCAN, EMIT, DONE
- done  out  1  one-cycle pulse at scan end
- piece_count  out  CNT_W  pieces emitted by the last scan; held until the next start

Behaviour:
- Reset:
  - All 64 board entries become EMPTY (6'b000000).
  - State returns to IDLE; scan index clears to 0.
  - All outputs go to 0, including out_valid, busy, done, piece_count, piece_reg, pos_reg and engine_color.
  - Reset mid-scan aborts with no done pulse.
- Board writes:
  - Accepted only in IDLE; wr_en in any other state is ignored.
  - A write is visible to a scan started on the next cycle.
  - If wr_en and start are high in the same IDLE cycle, the write lands before the scan reads it.
- Piece match rule: type != 00000 and piece bit 5 == latched engine_color. Type codes are not otherwise checked.
- IDLE:
  - On start: latch color_in into engine_color, set idx = 0, clear piece_count, go to SCAN.
  - start outside IDLE is ignored.
- SCAN (one square per cycle):
  - Match: register piece_reg = board[idx], pos_reg = idx, set out_valid = 1, go to EMIT.
  - No match with idx == 63: go to DONE.
  - No match otherwise: idx + 1, stay in SCAN.
- EMIT:
  - Hold out_valid and all payload stable until out_ready is high.
  - On handshake: drop out_valid, piece_count + 1, then go to DONE if idx == 63, else idx + 1 and return to SCAN.
  - out_ready high while out_valid is low has no effect.
- DONE: done = 1 for exactly one cycle, then IDLE (busy drops the following cycle).
- Timing, with start accepted at the edge ending cycle 0 and out_ready tied high:
  - Empty board: SCAN in cycles 1..64, done in cycle 65.
  - Each emitted piece adds exactly one cycle.
  - A backpressure stall adds one cycle per cycle out_ready is low.
- Ordering: pieces emitted strictly by ascending square index. No square is skipped or repeated.
- piece_count saturates naturally at 64 (fits CNT_W = 7).

Decomposition:
- Shared package (e.g. chess_pkg):
  - Piece type constants: EMPTY 00000, PAWN 00010, KNIGHT 00001, BISHOP 01000, ROOK 10000, QUEEN 11000, KING 00100.
  - Colour constants WHITE = 1, BLACK = 0.
  - Scanner state encoding.
  - SQ_W and PIECE_W.
- One natural sub-module: board_ram, a 64x6 register file with one synchronous write port, one asynchronous read port and synchronous reset-to-EMPTY. The FSM and counters stay in board_scanner.

Test Plan:
- Reset, then start with color_in = 1 on an empty board, out_ready = 1 -> no out_valid; done pulses 65 cycles after start; piece_count = 0.
- Write 6'b100010 (white PAWN) at square 2, start with color_in = 1 -> single handshake with piece_reg = 100010, pos_reg = 000010, engine_color = 1; done at cycle 66; piece_count = 1.
- Place white KNIGHT (100001) at 1, black ROOK (010000) at 5, white KING (100100) at 63, start with color_in = 0 -> only pos 5 / 010000 emitted; piece_count = 1.
- Same board, color_in = 1, out_ready low for 3 cycles on first valid -> payload stable while stalled; emits pos 1 then 63; done at cycle 70; piece_count = 2.
- Assert wr_en and start mid-scan -> board unchanged and scan unaffected; re-scan yields identical output sequence.
- Assert rst while in EMIT -> out_valid, busy and piece_count are 0 next cycle; no done pulse; board reads all EMPTY on the following scan.

Source files
------------

// File: rtl/board_scanner_pkg.sv
// Shared definitions for the board scanner: widths, piece/colour codes,
// scanner state encoding and the piece match rule.
package board_scanner_pkg;

  localparam int SQ_W    = 6;  // square index: [5:3] rank, [2:0] file
  localparam int PIECE_W = 6;  // bit 5 colour, [4:0] type
  localparam int CNT_W   = 7;  // emitted-piece count, 0..64
  localparam int NUM_SQ  = 64;

  localparam logic [SQ_W-1:0] LAST_SQ = 6'd63;

  typedef enum logic [4:0] {
    TYPE_EMPTY  = 5'b00000,
    TYPE_KNIGHT = 5'b00001,
    TYPE_PAWN   = 5'b00010,
    TYPE_KING   = 5'b00100,
    TYPE_BISHOP = 5'b01000,
    TYPE_ROOK   = 5'b10000,
    TYPE_QUEEN  = 5'b11000
  } piece_type_e;

  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

  // A square is emitted when it holds a piece of the engine's colour.
  // Type codes beyond "non-empty" are deliberately not validated here.
  function automatic logic piece_matches(input logic [PIECE_W-1:0] piece,
                                         input logic               color);
    return (piece[4:0] != TYPE_EMPTY) && (piece[5] == color);
  endfunction

endpackage

// File: rtl/board_ram.sv
// 64x6 board register file: one synchronous write port, one asynchronous
// read port, synchronous reset of every square to EMPTY.
module board_ram
  import board_scanner_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SQ_W-1:0]    wr_addr,
  input  logic [PIECE_W-1:0] wr_data,
  input  logic [SQ_W-1:0]    rd_addr,
  output logic [PIECE_W-1:0] rd_data
);

  logic [PIECE_W-1:0] mem [NUM_SQ];

  // Board storage: clear on reset, otherwise accept one write per cycle.
  // NOTE: this array is reset explicitly because a reset must leave the board
  // empty; that forces flops rather than a RAM macro, which is fine at 64x6.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SQ; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the scanner sees the square it is pointing at now.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/board_scanner.sv
// Board scanner: holds the board image and, on start, walks squares 0..63,
// handing every square owned by the engine's colour to the Transmitter over
// a valid/ready handshake, then pulses done.
module board_scanner
  import board_scanner_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SQ_W-1:0]    wr_addr,
  input  logic [PIECE_W-1:0] wr_data,
  input  logic               start,
  input  logic               color_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [PIECE_W-1:0] piece_reg,
  output logic [SQ_W-1:0]    pos_reg,
  output logic               engine_color,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   piece_count
);

  scan_state_e        state, state_n;
  logic [SQ_W-1:0]    idx, idx_n;
  logic [PIECE_W-1:0] piece_n;
  logic [SQ_W-1:0]    pos_n;
  logic               color_n;
  logic [CNT_W-1:0]   count_n;
  logic [PIECE_W-1:0] rd_data;
  logic               ram_wr_en;

  // The board is only writable while no scan is in progress.
  assign ram_wr_en = wr_en && (state == ST_IDLE);

  board_ram u_board_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // State and datapath registers; reset aborts any scan without a done pulse.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values computed by the combinational block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      piece_reg    <= '0;
      pos_reg      <= '0;
      engine_color <= 1'b0;
      piece_count  <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      piece_reg    <= piece_n;
      pos_reg      <= pos_n;
      engine_color <= color_n;
      piece_count  <= count_n;
    end
  end

  // Next-state and datapath updates for the IDLE/SCAN/EMIT/DONE walk.
  // NOTE: every next value defaults to its current register first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    piece_n = piece_reg;
    pos_n   = pos_reg;
    color_n = engine_color;
    count_n = piece_count;

    case (state)
      ST_IDLE: begin
        if (start) begin
          color_n = color_in;
          idx_n   = '0;
          count_n = '0;
          state_n = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (piece_matches(rd_data, engine_color)) begin
          piece_n = rd_data;
          pos_n   = idx;
          state_n = ST_EMIT;
        end else if (idx == LAST_SQ) begin
          state_n = ST_DONE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end

      ST_EMIT: begin
        // Payload registers are untouched here, so they stay stable while
        // the Transmitter holds out_ready low.
        if (out_ready) begin
          count_n = piece_count + 1'b1;
          if (idx == LAST_SQ) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = ST_SCAN;
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Handshake and status flags decode directly from the state register.
  assign out_valid = (state == ST_EMIT);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_board_scanner.sv
// Directed self-checking bench for board_scanner.
module tb_board_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [5:0] wr_data;
  logic       start;
  logic       color_in;
  logic       out_ready;
  logic       out_valid;
  logic [5:0] piece_reg;
  logic [5:0] pos_reg;
  logic       engine_color;
  logic       busy;
  logic       done;
  logic [6:0] piece_count;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent run_scan
  logic [5:0] em_pos   [64];
  logic [5:0] em_piece [64];
  logic       em_color [64];
  int         n_emit;
  int         done_cyc;

  board_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .color_in     (color_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .piece_reg    (piece_reg),
    .pos_reg      (pos_reg),
    .engine_color (engine_color),
    .busy         (busy),
    .done         (done),
    .piece_count  (piece_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_sq(input logic [5:0] addr, input logic [5:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Start a scan (start accepted at the edge ending cycle 0), record every
  // handshake, stall the first valid for 'stall' cycles, and optionally
  // inject a write + start during cycle 'inject_cyc'.
  task automatic run_scan(input logic color, input int stall, input int inject_cyc);
    int         cyc;
    int         stall_left;
    bit         holding;
    logic [5:0] hold_piece;
    logic [5:0] hold_pos;
    n_emit     = 0;
    done_cyc   = -1;
    stall_left = stall;
    holding    = 0;
    hold_piece = '0;
    hold_pos   = '0;
    color_in   = color;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 300 && done_cyc < 0) begin
      if (cyc == inject_cyc) begin
        wr_en    = 1'b1;
        wr_addr  = 6'd40;
        wr_data  = 6'b111000;
        start    = 1'b1;
        color_in = ~color;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (holding) begin
          n_checks++;
          if (piece_reg !== hold_piece || pos_reg !== hold_pos) begin
            n_errors++;
            $display("FAIL stall_stable cyc %0d: got piece %b pos %0d, need piece %b pos %0d",
                     cyc, piece_reg, pos_reg, hold_piece, hold_pos);
          end
        end
        if (stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left--;
          holding    = 1;
          hold_piece = piece_reg;
          hold_pos   = pos_reg;
        end else begin
          out_ready = 1'b1;
          holding   = 0;
          if (n_emit < 64) begin
            em_pos[n_emit]   = pos_reg;
            em_piece[n_emit] = piece_reg;
            em_color[n_emit] = engine_color;
          end
          n_emit++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done === 1'b1) done_cyc = cyc;
      tick();
      cyc++;
    end
    wr_en     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (done_cyc < 0) begin
      n_errors++;
      $display("FAIL scan_timeout: got no done within 300 cycles, need done");
    end else if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_width: cycle after done got done %b busy %b, need 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; color_in = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({out_valid, busy, done, piece_count, piece_reg, pos_reg, engine_color} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid %b busy %b done %b cnt %0d piece %b pos %0d color %b, need all 0",
               out_valid, busy, done, piece_count, piece_reg, pos_reg, engine_color);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty_board;
    run_scan(1'b1, 0, 0);
    n_checks++;
    if (n_emit != 0 || done_cyc != 65 || piece_count !== 7'd0) begin
      n_errors++;
      $display("FAIL empty_board: got emits %0d done_cyc %0d cnt %0d, need 0 65 0",
               n_emit, done_cyc, piece_count);
    end
  endtask

  task automatic test_single_pawn;
    write_sq(6'd2, 6'b100010);
    run_scan(1'b1, 0, 0);
    n_checks++;
    if (n_emit != 1 || done_cyc != 66 || piece_count !== 7'd1) begin
      n_errors++;
      $display("FAIL pawn_timing: got emits %0d done_cyc %0d cnt %0d, need 1 66 1",
               n_emit, done_cyc, piece_count);
    end
    n_checks++;
    if (em_piece[0] !== 6'b100010 || em_pos[0] !== 6'b000010 || em_color[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL pawn_payload: got piece %b pos %b color %b, need 100010 000010 1",
               em_piece[0], em_pos[0], em_color[0]);
    end
  endtask

  task automatic test_black_side;
    write_sq(6'd2, 6'b000000);
    write_sq(6'd1, 6'b100001);
    write_sq(6'd5, 6'b010000);
    // King at 63 is written in the same IDLE cycle as start
    wr_en = 1'b1; wr_addr = 6'd63; wr_data = 6'b100100;
    run_scan(1'b0, 0, 0);
    n_checks++;
    if (n_emit != 1 || done_cyc != 66 || piece_count !== 7'd1) begin
      n_errors++;
      $display("FAIL black_timing: got emits %0d done_cyc %0d cnt %0d, need 1 66 1",
               n_emit, done_cyc, piece_count);
    end
    n_checks++;
    if (em_piece[0] !== 6'b010000 || em_pos[0] !== 6'd5 || em_color[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL black_payload: got piece %b pos %0d color %b, need 010000 5 0",
               em_piece[0], em_pos[0], em_color[0]);
    end
  endtask

  task automatic test_backpressure;
    run_scan(1'b1, 3, 0);
    n_checks++;
    if (n_emit != 2 || done_cyc != 70 || piece_count !== 7'd2) begin
      n_errors++;
      $display("FAIL stall_timing: got emits %0d done_cyc %0d cnt %0d, need 2 70 2",
               n_emit, done_cyc, piece_count);
    end
    n_checks++;
    if (em_pos[0] !== 6'd1 || em_piece[0] !== 6'b100001 ||
        em_pos[1] !== 6'd63 || em_piece[1] !== 6'b100100) begin
      n_errors++;
      $display("FAIL stall_order: got %0d/%b then %0d/%b, need 1/100001 then 63/100100",
               em_pos[0], em_piece[0], em_pos[1], em_piece[1]);
    end
  endtask

  task automatic test_busy_ignore;
    // wr_en + start (with flipped colour) injected in cycle 12 of the scan
    for (int pass = 0; pass < 2; pass++) begin
      run_scan(1'b1, 0, (pass == 0) ? 12 : 0);
      n_checks++;
      if (n_emit != 2 || done_cyc != 67 || piece_count !== 7'd2) begin
        n_errors++;
        $display("FAIL busy_ignore_timing pass %0d: got emits %0d done_cyc %0d cnt %0d, need 2 67 2",
                 pass, n_emit, done_cyc, piece_count);
      end
      n_checks++;
      if (em_pos[0] !== 6'd1 || em_pos[1] !== 6'd63 ||
          em_piece[0] !== 6'b100001 || em_piece[1] !== 6'b100100 ||
          em_color[0] !== 1'b1 || em_color[1] !== 1'b1) begin
        n_errors++;
        $display("FAIL busy_ignore_seq pass %0d: got %0d/%b/%b then %0d/%b/%b, need 1/100001/1 then 63/100100/1",
                 pass, em_pos[0], em_piece[0], em_color[0], em_pos[1], em_piece[1], em_color[1]);
      end
    end
  endtask

  task automatic test_reset_mid_emit;
    int seen_done;
    seen_done = 0;
    color_in  = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) tick();
    tick();  // handshake square 1
    out_ready = 1'b0;
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) tick();
    n_checks++;
    if (out_valid !== 1'b1 || pos_reg !== 6'd63 || piece_count !== 7'd1) begin
      n_errors++;
      $display("FAIL pre_reset_emit: got valid %b pos %0d cnt %0d, need 1 63 1",
               out_valid, pos_reg, piece_count);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || piece_count !== 7'd0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_emit: got valid %b busy %b cnt %0d done %b, need 0 0 0 0",
               out_valid, busy, piece_count, done);
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen_done = 1;
      tick();
    end
    n_checks++;
    if (seen_done != 0) begin
      n_errors++;
      $display("FAIL reset_no_done: got done pulse after reset, need none");
    end
    for (int c = 0; c < 2; c++) begin
      run_scan(c[0], 0, 0);
      n_checks++;
      if (n_emit != 0 || done_cyc != 65 || piece_count !== 7'd0) begin
        n_errors++;
        $display("FAIL board_cleared color %0d: got emits %0d done_cyc %0d cnt %0d, need 0 65 0",
                 c, n_emit, done_cyc, piece_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_single_pawn();
    test_black_side();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
